// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the MIPS bus arbiter slice.
//                Holds the arbiter FSM state type, the requester port type,
//                the CPU reset vector and a word-alignment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } arb_port_t;

  localparam logic [31:0] c_reset_vector = 32'hBFC0_0000;
  localparam logic [31:0] c_word_mask    = 32'hFFFF_FFFC;

  // The Avalon side is word addressed in bytes: low two bits never leave the arbiter.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & c_word_mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mips_arb_pick
//  Description : Combinational winner selection between the instruction-fetch
//                and data-memory requesters. On a tie the port that was NOT
//                granted last wins; tying i_last to PORT_IF yields fixed DM
//                priority.
//  Ports       : i_if_req  - IF request
//                i_dm_req  - DM request
//                i_last    - last granted port
//                o_grant   - some requester is present
//                o_winner  - selected port (valid when o_grant)
//  Revision    : 1.0  initial release
// ============================================================================
module mips_arb_pick
  import mips_pkg::*;
(
  input  logic      i_if_req,
  input  logic      i_dm_req,
  input  arb_port_t i_last,
  output logic      o_grant,
  output arb_port_t o_winner
);

  always_comb begin
    o_grant  = i_if_req | i_dm_req;
    o_winner = PORT_IF;
    if (i_dm_req && !i_if_req) begin
      o_winner = PORT_DM;
    end else if (i_if_req && !i_dm_req) begin
      o_winner = PORT_IF;
    end else if (i_if_req && i_dm_req) begin
      o_winner = (i_last == PORT_IF) ? PORT_DM : PORT_IF;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_arbiter
//  Description : Shares one Avalon-MM master between the IF (read-only) and
//                DM (read/write) requesters. IDLE -> ISSUE -> RESP per
//                transfer; bus strobes are held while waitrequest is high,
//                readdata is registered into rdata and the owner receives a
//                one-cycle done pulse. Optional waitrequest watchdog.
//  Config      : `define MIPS_ARB_ROUND_ROBIN_EN -> round-robin tie-break
//                (otherwise fixed DM priority).
//  Parameters  : WAIT_LIMIT - waitrequest cycles in ISSUE that set stall_err
//                             (0 disables the watchdog)
//  Ports       : clk, reset (async, active-high)
//                if_req/if_addr/if_done            - IF requester
//                dm_req/dm_write/dm_addr/dm_wdata/dm_be/dm_done - DM requester
//                rdata                             - registered read data
//                address/read/write/writedata/byteenable/waitrequest/readdata
//                                                  - Avalon master
//                busy, stall_err                   - status
//  Revision    : 1.0  initial release
// ============================================================================
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int WAIT_LIMIT = 0
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic        dm_done,
  output logic [31:0] rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        stall_err
);

  localparam logic [15:0] c_wait_limit = WAIT_LIMIT[15:0];

  arb_state_t  r_state;
  arb_port_t   r_owner;
  arb_port_t   w_last;
  arb_port_t   w_winner;
  logic        w_grant;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_nxt;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
  arb_port_t   r_last;
  assign w_last = r_last;
`else
  // Pretending IF was always granted last makes the picker favour DM on ties.
  assign w_last = PORT_IF;
`endif

  mips_arb_pick u_pick (
    .i_if_req (if_req),
    .i_dm_req (dm_req),
    .i_last   (w_last),
    .o_grant  (w_grant),
    .o_winner (w_winner)
  );

  // Saturate so a bus stuck forever cannot wrap the counter past the limit.
  assign w_wait_nxt = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_owner    <= PORT_IF;
      r_wait_cnt <= 16'd0;
      address    <= 32'd0;
      writedata  <= 32'd0;
      byteenable <= 4'b0000;
      read       <= 1'b0;
      write      <= 1'b0;
      rdata      <= 32'd0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      stall_err  <= 1'b0;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
      r_last     <= PORT_IF;
`endif
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner    <= w_winner;
            r_wait_cnt <= 16'd0;
            r_state    <= ISSUE;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
            r_last     <= w_winner;
`endif
            if (w_winner == PORT_DM) begin
              address    <= word_align(dm_addr);
              writedata  <= dm_wdata;
              byteenable <= dm_be;
              read       <= ~dm_write;
              write      <= dm_write;
            end else begin
              // IF has no write data; writedata keeps its previous value.
              address    <= word_align(if_addr);
              byteenable <= 4'b1111;
              read       <= 1'b1;
              write      <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (waitrequest) begin
            r_wait_cnt <= w_wait_nxt;
            if ((WAIT_LIMIT != 0) && (w_wait_nxt == c_wait_limit)) begin
              stall_err <= 1'b1;
            end
          end else begin
            if (read) begin
              rdata <= readdata;
            end
            read    <= 1'b0;
            write   <= 1'b0;
            if (r_owner == PORT_DM) begin
              dm_done <= 1'b1;
            end else begin
              if_done <= 1'b1;
            end
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
